// File: rtl/flash_rom_loader_pkg.sv
// Shared definitions for the flash-to-RAM image loader: FSM encoding, default
// handshake timing and the flash offsets of the VIC-20 ROM images.
package flash_rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_REQ,
        ST_ACK,
        ST_XFER,
        ST_WRITE,
        ST_DONE
    } state_t;

    // The reader resynchronises cs through two flops, so the strobe must
    // stay high for at least two of our cycles.
    localparam int CS_HOLD_DEFAULT = 3;
    localparam int REQ_TO_DEFAULT  = 15;

    // One counter serves both the cs hold and the ack timeout.
    localparam int CNT_W = 4;

    localparam logic [23:0] KERNAL_FLASH_BASE = 24'h010000;
    localparam logic [23:0] BASIC_FLASH_BASE  = 24'h012000;
    localparam logic [23:0] CHAR_FLASH_BASE   = 24'h014000;
    localparam logic [23:0] CART_FLASH_BASE   = 24'h020000;

endpackage

// File: rtl/flash_rom_loader.sv
// Copy engine: reads a byte range from SPI flash through the DSPI reader's
// cs/busy/dout handshake and writes each byte into on-chip RAM.
module flash_rom_loader
    import flash_rom_loader_pkg::*;
#(
    parameter int DST_W   = 16,
    parameter int LEN_W   = 16,
    parameter int CS_HOLD = CS_HOLD_DEFAULT,
    parameter int REQ_TO  = REQ_TO_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [23:0]      src_addr,
    input  logic [DST_W-1:0] dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             flash_ready,
    output logic [23:0]      flash_addr,
    output logic             flash_cs,
    input  logic             flash_busy,
    input  logic [7:0]       flash_dout,
    output logic [DST_W-1:0] ram_addr,
    output logic [7:0]       ram_data,
    output logic             ram_we
);

    localparam logic [CNT_W-1:0] CS_LAST = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(REQ_TO - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [23:0]        src_q;
    logic [DST_W-1:0]   dst_q;
    logic [LEN_W-1:0]   rem_q;
    logic               error_q;
    logic [DST_W-1:0]   ram_addr_q;
    logic [7:0]         ram_data_q;

    // NOTE: state_d is given a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = (length == '0) ? ST_DONE : ST_WAIT_RDY;
            ST_WAIT_RDY: if (flash_ready && !flash_busy) state_d = ST_REQ;
            ST_REQ:      if (cnt_q == CS_LAST) state_d = ST_ACK;
            // busy seen while cs is still high may be stale; only trust it here
            ST_ACK: begin
                if (flash_busy)            state_d = ST_XFER;
                else if (cnt_q == TO_LAST) state_d = ST_DONE;
            end
            ST_XFER:     if (!flash_busy) state_d = ST_WRITE;
            ST_WRITE:    state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_REQ;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            error_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q <= state_d;
            // Counts from REQ entry through ACK; zero everywhere else.
            cnt_q   <= (state_q == ST_REQ || state_q == ST_ACK) ? cnt_q + CNT_W'(1) : '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= length;
                        error_q <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!flash_busy && cnt_q == TO_LAST) error_q <= 1'b1;
                end
                ST_XFER: begin
                    if (!flash_busy) begin
                        ram_data_q <= flash_dout;
                        ram_addr_q <= dst_q;
                    end
                end
                ST_WRITE: begin
                    src_q <= src_q + 24'd1;
                    dst_q <= dst_q + DST_W'(1);
                    rem_q <= rem_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = error_q;
    assign flash_cs   = (state_q == ST_REQ);
    assign flash_addr = src_q;
    assign ram_we     = (state_q == ST_WRITE);
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Directed/randomised bench for flash_rom_loader with a behavioural flash reader
// and a reference model of the expected RAM writes and flash requests.
module tb_flash_rom_loader;

    localparam int DST_W   = 16;
    localparam int LEN_W   = 16;
    localparam int CS_HOLD = 3;
    localparam int REQ_TO  = 15;

    logic             clk         = 1'b0;
    logic             resetn      = 1'b0;
    logic             start       = 1'b0;
    logic [23:0]      src_addr    = '0;
    logic [DST_W-1:0] dst_addr    = '0;
    logic [LEN_W-1:0] length      = '0;
    logic             flash_ready = 1'b0;
    logic             flash_busy  = 1'b0;
    logic [7:0]       flash_dout  = '0;
    logic             busy, done, error, flash_cs, ram_we;
    logic [23:0]      flash_addr;
    logic [DST_W-1:0] ram_addr;
    logic [7:0]       ram_data;

    always #5 clk = ~clk;

    flash_rom_loader #(.DST_W(DST_W), .LEN_W(LEN_W), .CS_HOLD(CS_HOLD), .REQ_TO(REQ_TO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .error(error), .flash_ready(flash_ready),
        .flash_addr(flash_addr), .flash_cs(flash_cs), .flash_busy(flash_busy),
        .flash_dout(flash_dout), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we)
    );

    int       checks = 0;
    int       errors = 0;
    logic [7:0] key = 8'h00;
    bit       no_ack = 1'b0;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ (a[23:16] + 8'h3C) ^ key;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reader model: busy rises 3 cycles after the cs rising edge, stays 22 cycles.
    int          rd_cnt  = 0;
    logic        rd_prev = 1'b0;
    logic [23:0] rd_addr = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            flash_busy = 1'b0;
            rd_cnt     = 0;
            rd_prev    = 1'b0;
        end else begin
            if (flash_cs && !rd_prev && !no_ack) begin
                rd_addr = flash_addr;
                rd_cnt  = 1;
            end else if (rd_cnt > 0) begin
                rd_cnt++;
                if (rd_cnt == 4) flash_busy = 1'b1;
                if (rd_cnt == 26) begin
                    flash_busy = 1'b0;
                    flash_dout = flash_byte(rd_addr);
                    rd_cnt     = 0;
                end
            end
            rd_prev = flash_cs;
        end
    end

    // Observation of requests, writes and done pulses.
    logic [23:0]      cs_q[$];
    logic [DST_W-1:0] wa_q[$];
    logic [7:0]       wd_q[$];
    int   cyc = 0, done_cnt = 0, done_cyc = 0, cs_rise_cyc = 0, cs_run = 0, cs_width = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            mon_prev = 1'b0;
        end else begin
            if (flash_cs && !mon_prev) begin
                cs_q.push_back(flash_addr);
                cs_rise_cyc = cyc;
                cs_run      = 0;
            end
            if (flash_cs) cs_run++;
            if (!flash_cs && mon_prev) cs_width = cs_run;
            if (ram_we) begin
                wa_q.push_back(ram_addr);
                wd_q.push_back(ram_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            mon_prev = flash_cs;
        end
    end

    task automatic start_xfer(input logic [23:0] s, input logic [DST_W-1:0] d, input logic [LEN_W-1:0] n);
        @(negedge clk);
        cs_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0;
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_addr = 24'($urandom);
        dst_addr = DST_W'($urandom);
        length   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget, input bit pulse);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = pulse && (i % 5 == 2);
            if (start) begin
                src_addr = 24'($urandom);
                dst_addr = DST_W'($urandom);
                length   = LEN_W'($urandom_range(1, 40));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    task automatic check_xfer(input string tag, input logic [23:0] s, input logic [DST_W-1:0] d, input int n);
        check({tag, "_we_count"}, wa_q.size(), n);
        check({tag, "_cs_count"}, cs_q.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [23:0]      es = s + 24'(i);
            logic [DST_W-1:0] ed = d + DST_W'(i);
            if (i < cs_q.size()) check({tag, "_flash_addr"}, cs_q[i], es);
            if (i < wa_q.size()) begin
                check({tag, "_ram_addr"}, wa_q[i], ed);
                check({tag, "_ram_data"}, wd_q[i], flash_byte(es));
            end
        end
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [23:0]      rs;
        logic [DST_W-1:0] rd;
        int               rn;

        // Reset values.
        #2;
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_error", error, 0);     check("rst_cs", flash_cs, 0);
        check("rst_faddr", flash_addr, 0); check("rst_we", ram_we, 0);
        check("rst_raddr", ram_addr, 0);  check("rst_rdata", ram_data, 0);
        @(negedge clk);
        resetn = 1'b1;
        key    = 8'($urandom);

        // 1: reader not ready for 50 cycles, then a 4-byte copy.
        start_xfer(24'h010000, 16'h0000, 16'd4);
        repeat (50) @(negedge clk);
        check("t1_no_cs_before_ready", cs_q.size(), 0);
        check("t1_busy_waiting", busy, 1);
        flash_ready = 1'b1;
        wait_done("t1", 4 * 40 + 50, 1'b0);
        check_xfer("t1", 24'h010000, 16'h0000, 4);

        // 2: zero length completes immediately without touching flash or RAM.
        start_xfer(24'h123456, 16'h4000, 16'd0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        @(negedge clk);
        check("t2_done_drop", done, 0);
        check("t2_busy_after", busy, 0);
        check("t2_no_cs", cs_q.size(), 0);
        check("t2_no_we", wa_q.size(), 0);

        // 3: reader never answers -> timeout error after REQ_TO cycles.
        no_ack = 1'b1;
        start_xfer(24'h014000, 16'h2000, 16'd2);
        wait_done("t3", 80, 1'b0);
        check("t3_cs_width", cs_width, CS_HOLD);
        check("t3_timeout_cycles", done_cyc - cs_rise_cyc, REQ_TO);
        check("t3_error", error, 1);
        check("t3_no_we", wa_q.size(), 0);
        check("t3_one_req", cs_q.size(), 1);
        repeat (5) @(negedge clk);
        check("t3_error_sticky", error, 1);
        no_ack = 1'b0;
        start_xfer(24'h000100, 16'h0100, 16'd1);
        check("t3_error_cleared", error, 0);
        wait_done("t3b", 90, 1'b0);
        check_xfer("t3b", 24'h000100, 16'h0100, 1);

        // 4: source and destination wrap.
        start_xfer(24'hFFFFFE, 16'hFFFF, 16'd3);
        wait_done("t4", 3 * 40 + 50, 1'b0);
        check_xfer("t4", 24'hFFFFFE, 16'hFFFF, 3);
        if (cs_q.size() == 3 && wa_q.size() == 3) begin
            check("t4_faddr2", cs_q[2], 24'h000000);
            check("t4_raddr0", wa_q[0], 16'hFFFF);
            check("t4_raddr1", wa_q[1], 16'h0000);
        end else begin
            check("t4_sizes", cs_q.size() + wa_q.size(), 6);
        end

        // 5: start pulses while busy are ignored.
        start_xfer(24'h012000, 16'h1000, 16'd5);
        wait_done("t5", 5 * 40 + 50, 1'b1);
        check_xfer("t5", 24'h012000, 16'h1000, 5);

        // Random range.
        rs = 24'($urandom);
        rd = DST_W'($urandom);
        rn = $urandom_range(1, 6);
        start_xfer(rs, rd, LEN_W'(rn));
        wait_done("rand", rn * 40 + 50, 1'b0);
        check_xfer("rand", rs, rd, rn);

        // 6: reset during the second byte, then a clean 8-byte copy.
        start_xfer(24'h020000, 16'h8000, 16'd8);
        for (int i = 0; i < 200 && wa_q.size() < 1; i++) @(negedge clk);
        check("t6_first_byte", wa_q.size(), 1);
        repeat (15) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("t6_busy", busy, 0);        check("t6_done", done, 0);
        check("t6_error", error, 0);      check("t6_cs", flash_cs, 0);
        check("t6_faddr", flash_addr, 0); check("t6_we", ram_we, 0);
        check("t6_raddr", ram_addr, 0);   check("t6_rdata", ram_data, 0);
        @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        start_xfer(24'h020000, 16'h8000, 16'd8);
        wait_done("t6b", 8 * 40 + 50, 1'b0);
        check_xfer("t6b", 24'h020000, 16'h8000, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
